// File: rtl/uart_rx_ovs.sv
// rtl/uart_rx_ovs.sv - 16x oversampling UART receiver with majority vote and receive FIFO
//
// Optional feature macro: UART_RX_PARITY_EN (adds PARITY state and parity_err port).
//
// Ports:
//   clk        in   system clock, single domain
//   rstn       in   asynchronous active-low reset
//   rx         in   serial line, idle high, asynchronous to clk
//   data       out  FIFO head word, meaningful while valid=1
//   valid      out  FIFO not empty
//   ready      in   consumer pops the head word when valid && ready
//   frame_err  out  one-cycle pulse, stop bit sampled 0
//   overrun    out  one-cycle pulse, good frame dropped on a full FIFO
//   parity_err out  one-cycle pulse, parity mismatch (UART_RX_PARITY_EN only)
module uart_rx_ovs #(
  parameter int DIV        = 27,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);

  // Elaboration-time parameter legality checks.
  if (DIV < 2 || DIV > 65535) begin : g_bad_div
    $error("uart_rx_ovs: DIV out of range");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("uart_rx_ovs: DATA_BITS out of range");
  end
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 64 || (1 << AW) != FIFO_DEPTH) begin : g_bad_depth
    $error("uart_rx_ovs: FIFO_DEPTH must be a power of two in 2..64");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
    $error("uart_rx_ovs: PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_HIGH
  } state_t;

  state_t               state;
  logic                 rx_m, rx_s, rx_d;
  logic [15:0]          div_cnt;
  logic [3:0]           tick_cnt;
  logic [3:0]           bit_cnt;
  logic                 s7, s8;
  logic [DATA_BITS-1:0] shreg;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad;
`endif

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          count;

  logic tick, maj, stop_eval, good_frame, pop, full, push, drop;

  // Two-flop synchroniser plus one delayed copy for start-edge detection.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  always_comb begin
    tick      = (div_cnt == 16'(DIV - 1));
    // Majority of the tick-7 and tick-8 samples and the live tick-9 value.
    maj       = (s7 & s8) | (s7 & rx_s) | (s8 & rx_s);
    stop_eval = (state == STOP) && tick && (tick_cnt == 4'd9);
`ifdef UART_RX_PARITY_EN
    good_frame = stop_eval && maj && !par_bad;
`else
    good_frame = stop_eval && maj;
`endif
    pop  = valid && ready;
    full = (count == (AW + 1)'(FIFO_DEPTH));
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push = good_frame && (!full || pop);
    drop = good_frame && full && !pop;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      div_cnt   <= '0;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      s7        <= 1'b1;
      s8        <= 1'b1;
      shreg     <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (state != IDLE) begin
        div_cnt <= tick ? 16'd0 : div_cnt + 16'd1;
        if (tick) tick_cnt <= tick_cnt + 4'd1;
      end
      if (tick && tick_cnt == 4'd7) s7 <= rx_s;
      if (tick && tick_cnt == 4'd8) s8 <= rx_s;

      case (state)
        IDLE: begin
          if (rx_d && !rx_s) begin
            state    <= START;
            div_cnt  <= '0;
            tick_cnt <= '0;
          end
        end
        START: begin
          if (tick && tick_cnt == 4'd8) begin
            if (rx_s) begin
              state <= IDLE;
            end else begin
              state <= DATA;
              // All-ones marks the tail of the start bit still in progress;
              // it rolls over to bit 0 at the next tick 15.
              bit_cnt <= 4'hF;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (tick_cnt == 4'd9 && bit_cnt != 4'hF)
              shreg <= {maj, shreg[DATA_BITS-1:1]};
            if (tick_cnt == 4'd15) begin
              if (bit_cnt == 4'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick && tick_cnt == 4'd9)
            par_bad <= ((^shreg) ^ maj) != (PARITY_ODD != 0);
          if (tick && tick_cnt == 4'd15)
            state <= STOP;
        end
`endif
        STOP: begin
          if (stop_eval) begin
            if (maj) begin
              state   <= IDLE;
              overrun <= drop;
`ifdef UART_RX_PARITY_EN
              parity_err <= par_bad;
`endif
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_HIGH;
            end
          end
        end
        WAIT_HIGH: begin
          // A held-low line (break) must not be read as further frames.
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign data  = mem[rd_ptr];
  assign valid = (count != '0);

endmodule

// File: tb/tb_uart_rx_ovs.sv
// tb/tb_uart_rx_ovs.sv - directed table-driven bench for uart_rx_ovs (default 8N1 build)
module tb_uart_rx_ovs;
  localparam int DIV = 27;
  localparam int BIT = 16 * DIV;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       rx = 1'b1;
  logic       ready = 1'b1;
  logic [7:0] data;
  logic       valid, frame_err, overrun;

  always #5 clk = ~clk;

  uart_rx_ovs #(.DIV(DIV), .DATA_BITS(8), .FIFO_DEPTH(4), .PARITY_ODD(0)) dut (
    .clk(clk), .rstn(rstn), .rx(rx), .data(data), .valid(valid),
    .ready(ready), .frame_err(frame_err), .overrun(overrun)
  );

  int tests = 0, fails = 0;
  int cyc = 0;
  int ferr_cnt = 0, ovr_cnt = 0, long_pulse = 0, valid_cycles = 0, rise_cyc = -1;
  logic [7:0] got[$];
  logic ferr_q = 1'b0, ovr_q = 1'b0, valid_q = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rstn) begin
      if (valid && ready) got.push_back(data);
      if (valid) valid_cycles++;
      if (valid && !valid_q && rise_cyc < 0) rise_cyc = cyc;
      if (frame_err) ferr_cnt++;
      if (overrun) ovr_cnt++;
      if ((frame_err && ferr_q) || (overrun && ovr_q)) long_pulse++;
    end
    ferr_q  = frame_err;
    ovr_q   = overrun;
    valid_q = valid;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input int ncyc);
    rx = v;
    repeat (ncyc) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int extra_low);
    drive(1'b0, BIT);
    for (int i = 0; i < 8; i++) drive(d[i], BIT);
    drive(stop, BIT);
    if (!stop && extra_low > 0) drive(1'b0, extra_low * BIT);
    drive(1'b1, BIT);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       stop;
    int         extra_low;
    int         exp_push;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[5];
  int f0, o0, v0, c0;

  initial begin
    vecs[0] = '{d: 8'hA5, stop: 1'b1, extra_low: 0, exp_push: 1, exp_ferr: 0};
    vecs[1] = '{d: 8'h3C, stop: 1'b0, extra_low: 2, exp_push: 0, exp_ferr: 1};
    vecs[2] = '{d: 8'h55, stop: 1'b1, extra_low: 0, exp_push: 1, exp_ferr: 0};
    vecs[3] = '{d: 8'h00, stop: 1'b1, extra_low: 0, exp_push: 1, exp_ferr: 0};
    vecs[4] = '{d: 8'hFF, stop: 1'b1, extra_low: 0, exp_push: 1, exp_ferr: 0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", valid, 0);
    chk("rst_data", data, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_overrun", overrun, 0);
    rstn = 1'b1;
    drive(1'b1, BIT);

    // False start: low for 4 ticks only
    got.delete(); f0 = ferr_cnt; o0 = ovr_cnt; v0 = valid_cycles;
    drive(1'b0, 4 * DIV);
    drive(1'b1, 2 * BIT);
    chk("false_start_valid", valid_cycles - v0, 0);
    chk("false_start_frame_err", ferr_cnt - f0, 0);
    chk("false_start_overrun", ovr_cnt - o0, 0);

    // Table: good frames and a framing error with a held-low line
    for (int v = 0; v < 5; v++) begin
      got.delete(); f0 = ferr_cnt; o0 = ovr_cnt; v0 = valid_cycles; rise_cyc = -1;
      c0 = cyc;
      send_frame(vecs[v].d, vecs[v].stop, vecs[v].extra_low);
      chk($sformatf("vec%0d_push_count", v), got.size(), vecs[v].exp_push);
      if (vecs[v].exp_push != 0) begin
        chk($sformatf("vec%0d_data", v), got.size() > 0 ? int'(got[0]) : -1, int'(vecs[v].d));
        chk($sformatf("vec%0d_valid_latency", v),
            int'(rise_cyc >= c0 + 9 * BIT + BIT / 2 && rise_cyc <= c0 + 10 * BIT), 1);
        chk($sformatf("vec%0d_valid_cycles", v), valid_cycles - v0, 1);
      end
      chk($sformatf("vec%0d_frame_err", v), ferr_cnt - f0, vecs[v].exp_ferr);
      chk($sformatf("vec%0d_overrun", v), ovr_cnt - o0, 0);
    end

    // Overrun: five frames into a four-deep FIFO with ready low
    ready = 1'b0;
    got.delete(); f0 = ferr_cnt; o0 = ovr_cnt;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 0);
    chk("ovr_pulses", ovr_cnt - o0, 1);
    chk("ovr_frame_err", ferr_cnt - f0, 0);
    chk("ovr_valid_held", valid, 1);
    ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("ovr_drain_count", got.size(), 4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("ovr_drain_%0d", k), got.size() > k ? int'(got[k]) : -1, k + 1);
    chk("ovr_empty_after_drain", valid, 0);

    // Reset in the middle of a frame
    ready = 1'b0;
    send_frame(8'h11, 1'b1, 0);
    chk("mid_rst_prefill_valid", valid, 1);
    f0 = ferr_cnt; o0 = ovr_cnt;
    drive(1'b0, BIT);
    drive(1'b1, BIT);
    drive(1'b0, BIT);
    drive(1'b0, BIT);
    drive(1'b0, BIT);
    rx = 1'b0;
    repeat (BIT / 2) @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    chk("mid_rst_valid_async", valid, 0);
    chk("mid_rst_data", data, 0);
    rx = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rstn = 1'b1;
    drive(1'b1, BIT);
    chk("mid_rst_frame_err", ferr_cnt - f0, 0);
    chk("mid_rst_overrun", ovr_cnt - o0, 0);
    ready = 1'b1;
    got.delete();
    send_frame(8'h42, 1'b1, 0);
    chk("post_rst_count", got.size(), 1);
    chk("post_rst_data", got.size() > 0 ? int'(got[0]) : -1, 'h42);

    chk("pulse_width", long_pulse, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
